// File: rtl/rgb_pkg.sv
// Shared constants and types for the six-channel RGB PWM driver.
package rgb_pkg;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned DUTY_W = 4;
  localparam int unsigned PRE_W  = 16;

  localparam logic [2:0] SEL_BCAST = 3'd7;

  // Channel index == bit position on the LED bus.
  localparam int unsigned CH_R0 = 0;
  localparam int unsigned CH_G0 = 1;
  localparam int unsigned CH_B0 = 2;
  localparam int unsigned CH_R1 = 3;
  localparam int unsigned CH_G1 = 4;
  localparam int unsigned CH_B1 = 5;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t PWM_LAST = 4'hf;

  typedef struct packed {
    logic       wr;
    logic [2:0] sel;
    duty_t      duty;
  } wr_req_t;

  // Sel 6 matches nothing; broadcast matches every channel.
  function automatic logic sel_hits(logic [2:0] sel, int unsigned ch);
    return (sel == SEL_BCAST) || (sel == ch[2:0]);
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Write port and PWM outputs of the RGB PWM driver.
interface rgb_pwm_driver_if;
  import rgb_pkg::*;

  logic        En;
  logic        Wr;
  logic [2:0]  Sel;
  duty_t       Duty;
  logic [5:0]  Out;
  logic        Period_Start;

  modport master (
    output En,
    output Wr,
    output Sel,
    output Duty,
    input  Out,
    input  Period_Start
  );

  modport slave (
    input  En,
    input  Wr,
    input  Sel,
    input  Duty,
    output Out,
    output Period_Start
  );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: committed duty register and registered comparator.
module pwm_channel
  import rgb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  duty_t             shadow,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic              out
);

  duty_t active_q, active_d;
  logic  out_q, out_d;

  // While idle the active register follows the shadow so an enable starts with fresh values.
  always_comb begin
    active_d = active_q;
    if (!en || load) begin
      active_d = shadow;
    end
    out_d = en && (pwm_cnt < active_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
      out_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Six-channel PWM driver: prescaler, period counter, shadow registers and write decode.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned PRESCALE = 1000
) (
  input logic       clk,
  input logic       rst_n,
  rgb_pwm_driver_if.slave bus
);

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  duty_t             shadow_q [NUM_CH];
  duty_t             shadow_d [NUM_CH];
  logic              ps_q, ps_d;
  logic              tick;
  logic              commit;
  logic [NUM_CH-1:0] ch_out;
  wr_req_t           req;

  assign req    = '{wr: bus.Wr, sel: bus.Sel, duty: bus.Duty};
  assign tick   = bus.En && (pre_cnt_q == PreLast);
  assign commit = tick && (pwm_cnt_q == PWM_LAST);

  always_comb begin
    pre_cnt_d = '0;
    pwm_cnt_d = '0;
    if (bus.En) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
      pwm_cnt_d = pwm_cnt_q + {{(DUTY_W-1){1'b0}}, tick};
    end
    ps_d = commit;
  end

  // Commit samples shadow_q, so a write on the boundary cycle waits one more period.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (req.wr && sel_hits(req.sel, i)) begin
        shadow_d[i] = req.duty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      ps_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      ps_q      <= ps_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    pwm_channel u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.En),
      .load    (commit),
      .shadow  (shadow_q[g]),
      .pwm_cnt (pwm_cnt_q),
      .out     (ch_out[g])
    );
  end

  assign bus.Out = {ch_out[CH_B1], ch_out[CH_G1], ch_out[CH_R1],
                    ch_out[CH_B0], ch_out[CH_G0], ch_out[CH_R0]};
  assign bus.Period_Start = ps_q;

  idle_quiet_a: assert property (@(posedge clk) disable iff (!rst_n)
    !bus.En |=> (bus.Out == '0) && !bus.Period_Start);

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench: stimulus queues expected Out/Period_Start per cycle, a monitor compares.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;

  rgb_pwm_driver_if bus_a ();
  rgb_pwm_driver_if bus_b ();

  rgb_pwm_driver #(.PRESCALE(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  rgb_pwm_driver #(.PRESCALE(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         at;
    bit         dut;
    logic [5:0] out;
    logic       ps;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push(input int at, input bit dut, input logic [5:0] out, input logic ps,
                      input string tag);
    exp_t e;
    e.at  = at;
    e.dut = dut;
    e.out = out;
    e.ps  = ps;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Expected 16 cycles on DUT A (PRESCALE=1) for a period whose first output edge is base+1.
  // duties = {ch5, ch4, ch3, ch2, ch1, ch0}, 4 bits each.
  task automatic push_period_a(input int base, input logic [23:0] duties, input string tag);
    logic [5:0] o;
    logic [3:0] d;
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 6; i++) begin
        d    = duties[i*4 +: 4];
        o[i] = (p < int'(d));
      end
      push(base + p + 1, 1'b0, o, p == 15, tag);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at < cyc) begin
        check({mon_e.tag, " stale"}, mon_e.at, cyc);
      end else if (mon_e.dut) begin
        check({mon_e.tag, " out"}, int'(bus_b.Out), int'(mon_e.out));
        check({mon_e.tag, " ps"}, int'(bus_b.Period_Start), int'(mon_e.ps));
      end else begin
        check({mon_e.tag, " out"}, int'(bus_a.Out), int'(mon_e.out));
        check({mon_e.tag, " ps"}, int'(bus_a.Period_Start), int'(mon_e.ps));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_a(input logic [2:0] sel, input logic [3:0] duty);
    bus_a.Wr   = 1'b1;
    bus_a.Sel  = sel;
    bus_a.Duty = duty;
    cycles(1);
    bus_a.Wr   = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] sel, input logic [3:0] duty);
    bus_b.Wr   = 1'b1;
    bus_b.Sel  = sel;
    bus_b.Duty = duty;
    cycles(1);
    bus_b.Wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k0, c, e0, s, e1, r;
    rst_n_a    = 1'b0;
    rst_n_b    = 1'b0;
    bus_a.En   = 1'b1;
    bus_a.Wr   = 1'b0;
    bus_a.Sel  = 3'd0;
    bus_a.Duty = 4'd0;
    bus_b.En   = 1'b0;
    bus_b.Wr   = 1'b0;
    bus_b.Sel  = 3'd0;
    bus_b.Duty = 4'd0;

    cycles(2);
    check("reset out a", int'(bus_a.Out), 0);
    check("reset ps a", int'(bus_a.Period_Start), 0);
    check("reset out b", int'(bus_b.Out), 0);

    // 1: running with no writes, Period_Start every 16th cycle.
    rst_n_a = 1'b1;
    k0 = cyc;
    for (int p = 0; p < 4; p++) push_period_a(k0 + 16 * p, 24'h000000, "t1 nowrite");
    cycles(64);

    // 2: load while idle, then enable.
    bus_a.En = 1'b0;
    c = cyc;
    for (int j = 1; j <= 3; j++) push(c + j, 1'b0, 6'd0, 1'b0, "t2 idle");
    wr_a(3'd0, 4'd4);
    wr_a(3'd5, 4'd12);
    cycles(1);
    bus_a.En = 1'b1;
    e0 = cyc;
    push_period_a(e0,       24'hC00004, "t2 p0");
    push_period_a(e0 + 16,  24'hC00004, "t2 p1");
    push_period_a(e0 + 32,  24'hC00004, "t3 old");
    push_period_a(e0 + 48,  24'hC00008, "t3 new");
    push_period_a(e0 + 64,  24'hC00028, "t4 pre");
    push_period_a(e0 + 80,  24'hC000F8, "t4 post");
    push_period_a(e0 + 96,  24'h666666, "t5 bcast");
    push_period_a(e0 + 112, 24'h666666, "t5 sel6");

    // 3: mid-period write.
    cycles(34);
    wr_a(3'd0, 4'd8);
    // 4: old shadow 2, then 15 written on the commit edge.
    cycles(15);
    wr_a(3'd1, 4'd2);
    cycles(12);
    wr_a(3'd1, 4'd15);
    // 5: broadcast, then the ignored select.
    cycles(18);
    wr_a(3'd7, 4'd6);
    wr_a(3'd6, 4'd9);
    cycles(44);

    // 6: PRESCALE=3, duty 1, then asynchronous reset mid-pulse.
    cycles(1);
    rst_n_b = 1'b1;
    s = cyc;
    push(s + 1, 1'b1, 6'd0, 1'b0, "t6 idle");
    push(s + 2, 1'b1, 6'd0, 1'b0, "t6 idle");
    wr_b(3'd0, 4'd1);
    cycles(1);
    bus_b.En = 1'b1;
    e1 = cyc;
    for (int j = 1; j <= 97; j++) begin
      push(e1 + j, 1'b1, (((j - 1) % 48) < 3) ? 6'd1 : 6'd0, (j % 48) == 0, "t6 run");
    end
    cycles(98);
    check("t6 pre-reset out", int'(bus_b.Out), 1);
    #2;
    rst_n_b = 1'b0;
    #1;
    check("t6 async out", int'(bus_b.Out), 0);
    check("t6 async ps", int'(bus_b.Period_Start), 0);
    cycles(1);
    rst_n_b = 1'b1;
    r = cyc;
    for (int j = 1; j <= 48; j++) push(r + j, 1'b1, 6'd0, j == 48, "t6 cleared");
    cycles(48);
    for (int j = 49; j <= 99; j++) begin
      push(r + j, 1'b1, (j >= 97) ? 6'd1 : 6'd0, j == 96, "t6 rewrite");
    end
    wr_b(3'd0, 4'd1);
    cycles(51);

    for (int k = 0; k < 5 && sb.size() != 0; k++) cycles(1);
    check("scoreboard drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
